// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundle between the multicycle control FSM and its datapath.
//   master : controller side. Reads opcode/funct/zero/overflow and drives
//            every enable, select, alu_op, cause and state.
//   slave  : datapath side, the mirror of master.
// Signals:
//   opcode[5:0], funct[5:0]  instruction fields (IR[31:26], IR[5:0])
//   zero, overflow           combinational ALU flags for the current cycle
//   pc_write, iord, mem_wr, ir_write, a_write, b_write, aluout_write,
//   reg_write, reg_dst, mem_to_reg, alu_src_a, epc_write
//                            single-bit datapath enables/selects
//   alu_src_b[1:0]           00 B, 01 const 4, 10 sext(imm), 11 sext(imm)<<2
//   pc_source[1:0]           00 ALU, 01 ALUOut, 10 jump target, 11 exc vector
//   alu_op[ALUOP_W-1:0]      0 LOAD, 1 ADD, 2 SUB, 3 AND, 6 XOR
//   cause[1:0]               0 none, 1 invalid instruction, 2 overflow
//   state[3:0]               current FSM state code
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if #(
   parameter int ALUOP_W = 3
);
   logic [5:0]         opcode;
   logic [5:0]         funct;
   logic               zero;
   logic               overflow;
   logic               pc_write;
   logic               iord;
   logic               mem_wr;
   logic               ir_write;
   logic               a_write;
   logic               b_write;
   logic               aluout_write;
   logic               reg_write;
   logic               reg_dst;
   logic               mem_to_reg;
   logic               alu_src_a;
   logic               epc_write;
   logic [1:0]         alu_src_b;
   logic [1:0]         pc_source;
   logic [ALUOP_W-1:0] alu_op;
   logic [1:0]         cause;
   logic [3:0]         state;

   modport master (
      input  opcode, funct, zero, overflow,
      output pc_write, iord, mem_wr, ir_write, a_write, b_write,
             aluout_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
             epc_write, alu_src_b, pc_source, alu_op, cause, state
   );

   modport slave (
      output opcode, funct, zero, overflow,
      input  pc_write, iord, mem_wr, ir_write, a_write, b_write,
             aluout_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
             epc_write, alu_src_b, pc_source, alu_op, cause, state
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Control FSM for a multicycle MIPS-style datapath: FETCH/DECODE, R-type,
// immediate, load/store, branch, jump and exception sequencing.
// Parameters:
//   MEM_WAIT  extra wait cycles per memory read (0-7); FETCH and MEM_READ
//             each last MEM_WAIT+1 cycles
//   ALUOP_W   ALU operation code width (>= 3)
// Ports:
//   clock     rising-edge system clock
//   reset     asynchronous, active-low reset
//   bus       multicycle_ctrl_if.master (instruction fields and ALU flags
//             in; enables, selects, alu_op, cause and state out)
// Build option:
//   CTRL_OVF_EXC_EN  when defined, ALU overflow in EXEC_R (ADD/SUB) or
//                    EXEC_I diverts to EXC with cause 2 instead of the
//                    register write-back; otherwise overflow is ignored.
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter int MEM_WAIT = 0,
   parameter int ALUOP_W  = 3
) (
   input  logic                clock,
   input  logic                reset,
   multicycle_ctrl_if.master   bus
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_EXEC_R    = 4'd2,
      S_R_WB      = 4'd3,
      S_EXEC_I    = 4'd4,
      S_I_WB      = 4'd5,
      S_MEM_ADDR  = 4'd6,
      S_MEM_READ  = 4'd7,
      S_MEM_WB    = 4'd8,
      S_MEM_WRITE = 4'd9,
      S_BRANCH    = 4'd10,
      S_JUMP      = 4'd11,
      S_EXC       = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_XOR = 6'h26;

   localparam logic [ALUOP_W-1:0] ALU_LOAD = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(6);

   state_t     state;
   logic [2:0] wait_cnt;
   logic [1:0] cause_q;
   logic       wait_done;
   logic       funct_ok;

   assign wait_done = (wait_cnt == 3'(MEM_WAIT));
   assign funct_ok  = (bus.funct == FN_ADD) || (bus.funct == FN_SUB) ||
                      (bus.funct == FN_AND) || (bus.funct == FN_XOR);

   // State, wait counter and cause register. The counter defaults to zero
   // on every edge and only advances while a wait state is being held, so
   // any entry into FETCH or MEM_READ starts from zero.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= S_FETCH;
         wait_cnt <= 3'd0;
         cause_q  <= 2'd0;
      end else begin
         wait_cnt <= 3'd0;
         case (state)
            S_FETCH: begin
               if (wait_done) state <= S_DECODE;
               else           wait_cnt <= wait_cnt + 3'd1;
            end
            S_DECODE: begin
               case (bus.opcode)
                  OP_RTYPE:      state <= S_EXEC_R;
                  OP_ADDI:       state <= S_EXEC_I;
                  OP_LW, OP_SW:  state <= S_MEM_ADDR;
                  OP_BEQ, OP_BNE: state <= S_BRANCH;
                  OP_J:          state <= S_JUMP;
                  default: begin
                     state   <= S_EXC;
                     cause_q <= 2'd1;
                  end
               endcase
            end
            S_EXEC_R: begin
               if (!funct_ok) begin
                  state   <= S_EXC;
                  cause_q <= 2'd1;
               end
`ifdef CTRL_OVF_EXC_EN
               else if (bus.overflow &&
                        ((bus.funct == FN_ADD) || (bus.funct == FN_SUB))) begin
                  state   <= S_EXC;
                  cause_q <= 2'd2;
               end
`endif
               else begin
                  state <= S_R_WB;
               end
            end
            S_EXEC_I: begin
`ifdef CTRL_OVF_EXC_EN
               if (bus.overflow) begin
                  state   <= S_EXC;
                  cause_q <= 2'd2;
               end else begin
                  state <= S_I_WB;
               end
`else
               state <= S_I_WB;
`endif
            end
            S_MEM_ADDR: begin
               state <= (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
               if (wait_done) state <= S_MEM_WB;
               else           wait_cnt <= wait_cnt + 3'd1;
            end
            S_R_WB, S_I_WB, S_MEM_WB, S_MEM_WRITE,
            S_BRANCH, S_JUMP, S_EXC: begin
               state <= S_FETCH;
            end
            default: begin
               state <= S_FETCH;
            end
         endcase
      end
   end

   logic               pc_write_c;
   logic               iord_c;
   logic               mem_wr_c;
   logic               ir_write_c;
   logic               a_write_c;
   logic               b_write_c;
   logic               aluout_write_c;
   logic               reg_write_c;
   logic               reg_dst_c;
   logic               mem_to_reg_c;
   logic               alu_src_a_c;
   logic               epc_write_c;
   logic [1:0]         alu_src_b_c;
   logic [1:0]         pc_source_c;
   logic [ALUOP_W-1:0] alu_op_c;

   // Output decode from the current state; BRANCH also looks at zero
   // because the comparison result only exists during that cycle.
   always_comb begin
      pc_write_c     = 1'b0;
      iord_c         = 1'b0;
      mem_wr_c       = 1'b0;
      ir_write_c     = 1'b0;
      a_write_c      = 1'b0;
      b_write_c      = 1'b0;
      aluout_write_c = 1'b0;
      reg_write_c    = 1'b0;
      reg_dst_c      = 1'b0;
      mem_to_reg_c   = 1'b0;
      alu_src_a_c    = 1'b0;
      epc_write_c    = 1'b0;
      alu_src_b_c    = 2'b00;
      pc_source_c    = 2'b00;
      alu_op_c       = ALU_LOAD;
      case (state)
         S_FETCH: begin
            alu_src_b_c = 2'b01;
            alu_op_c    = ALU_ADD;
            ir_write_c  = wait_done;
            pc_write_c  = wait_done;
         end
         S_DECODE: begin
            a_write_c      = 1'b1;
            b_write_c      = 1'b1;
            aluout_write_c = 1'b1;
            alu_src_b_c    = 2'b11;
            alu_op_c       = ALU_ADD;
         end
         S_EXEC_R: begin
            alu_src_a_c    = 1'b1;
            aluout_write_c = 1'b1;
            case (bus.funct)
               FN_ADD:  alu_op_c = ALU_ADD;
               FN_SUB:  alu_op_c = ALU_SUB;
               FN_AND:  alu_op_c = ALU_AND;
               FN_XOR:  alu_op_c = ALU_XOR;
               default: alu_op_c = ALU_LOAD;
            endcase
         end
         S_R_WB: begin
            reg_write_c = 1'b1;
            reg_dst_c   = 1'b1;
         end
         S_I_WB: begin
            reg_write_c = 1'b1;
         end
         S_EXEC_I, S_MEM_ADDR: begin
            alu_src_a_c    = 1'b1;
            alu_src_b_c    = 2'b10;
            alu_op_c       = ALU_ADD;
            aluout_write_c = 1'b1;
         end
         S_MEM_READ: begin
            iord_c = 1'b1;
         end
         S_MEM_WB: begin
            reg_write_c  = 1'b1;
            mem_to_reg_c = 1'b1;
         end
         S_MEM_WRITE: begin
            iord_c   = 1'b1;
            mem_wr_c = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a_c = 1'b1;
            alu_op_c    = ALU_SUB;
            pc_source_c = 2'b01;
            pc_write_c  = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
         end
         S_JUMP: begin
            pc_source_c = 2'b10;
            pc_write_c  = 1'b1;
         end
         S_EXC: begin
            alu_src_b_c = 2'b01;
            alu_op_c    = ALU_SUB;
            epc_write_c = 1'b1;
            pc_source_c = 2'b11;
            pc_write_c  = 1'b1;
         end
         default: begin
            pc_write_c = 1'b0;
         end
      endcase
   end

   // Write enables are gated by reset so they drop the instant reset is
   // asserted, independent of any clock edge.
   assign bus.pc_write     = pc_write_c     & reset;
   assign bus.mem_wr       = mem_wr_c       & reset;
   assign bus.ir_write     = ir_write_c     & reset;
   assign bus.a_write      = a_write_c      & reset;
   assign bus.b_write      = b_write_c      & reset;
   assign bus.aluout_write = aluout_write_c & reset;
   assign bus.reg_write    = reg_write_c    & reset;
   assign bus.epc_write    = epc_write_c    & reset;
   assign bus.iord         = iord_c;
   assign bus.reg_dst      = reg_dst_c;
   assign bus.mem_to_reg   = mem_to_reg_c;
   assign bus.alu_src_a    = alu_src_a_c;
   assign bus.alu_src_b    = alu_src_b_c;
   assign bus.pc_source    = pc_source_c;
   assign bus.alu_op       = alu_op_c;
   assign bus.cause        = cause_q;
   assign bus.state        = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Scoreboard bench for multicycle_ctrl with MEM_WAIT=2. The stimulus
// process drives instruction fields and pushes the hand-written expected
// output vector for every cycle; a monitor pops and compares on each
// falling edge.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;
   localparam int MW = 2;

   localparam logic [11:0] PCW  = 12'h800;
   localparam logic [11:0] IORD = 12'h400;
   localparam logic [11:0] MWR  = 12'h200;
   localparam logic [11:0] IRW  = 12'h100;
   localparam logic [11:0] AW   = 12'h080;
   localparam logic [11:0] BW   = 12'h040;
   localparam logic [11:0] AOW  = 12'h020;
   localparam logic [11:0] RW   = 12'h010;
   localparam logic [11:0] RDST = 12'h008;
   localparam logic [11:0] M2R  = 12'h004;
   localparam logic [11:0] SRCA = 12'h002;
   localparam logic [11:0] EPCW = 12'h001;

   typedef struct packed {
      logic [3:0]  st;
      logic [11:0] en;
      logic [1:0]  srcb;
      logic [1:0]  pcsrc;
      logic [2:0]  aluop;
      logic [1:0]  cause;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   multicycle_ctrl_if #(.ALUOP_W(3)) bus();

   multicycle_ctrl #(.MEM_WAIT(MW), .ALUOP_W(3)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   exp_t  sb_q[$];
   string tag_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   logic [1:0] exp_cause = 2'd0;

   exp_t  mon_e;
   exp_t  mon_a;
   string mon_tag;

   // Monitor: every falling edge with a pending expectation is a check.
   initial begin
      forever begin
         @(negedge clock);
         if (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_tag = tag_q.pop_front();
            mon_a   = {bus.state,
                       {bus.pc_write, bus.iord, bus.mem_wr, bus.ir_write,
                        bus.a_write, bus.b_write, bus.aluout_write,
                        bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                        bus.alu_src_a, bus.epc_write},
                       bus.alu_src_b, bus.pc_source, bus.alu_op, bus.cause};
            n_tests++;
            if (mon_a !== mon_e) begin
               n_fail++;
               $display("FAIL %s: got st=%0d en=%h srcb=%b pcsrc=%b op=%0d cause=%0d, expected st=%0d en=%h srcb=%b pcsrc=%b op=%0d cause=%0d",
                        mon_tag, mon_a.st, mon_a.en, mon_a.srcb, mon_a.pcsrc,
                        mon_a.aluop, mon_a.cause, mon_e.st, mon_e.en,
                        mon_e.srcb, mon_e.pcsrc, mon_e.aluop, mon_e.cause);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Push the expectation for the current cycle, then advance one cycle.
   task automatic cyc(input logic [3:0] st, input logic [11:0] en,
                      input logic [1:0] srcb, input logic [1:0] pcsrc,
                      input logic [2:0] op, input string tag);
      sb_q.push_back({st, en, srcb, pcsrc, op, exp_cause});
      tag_q.push_back(tag);
      @(posedge clock);
      #1;
   endtask

   task automatic set_in(input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic ovf);
      bus.opcode   = op;
      bus.funct    = fn;
      bus.zero     = z;
      bus.overflow = ovf;
   endtask

   task automatic fetch();
      for (int i = 0; i <= MW; i++)
         cyc(4'd0, (i == MW) ? (PCW | IRW) : 12'h000, 2'b01, 2'b00, 3'd1, "fetch");
   endtask

   task automatic decode();
      cyc(4'd1, AW | BW | AOW, 2'b11, 2'b00, 3'd1, "decode");
   endtask

   task automatic exc(input logic [1:0] c);
      exp_cause = c;
      cyc(4'd12, PCW | EPCW, 2'b01, 2'b11, 3'd2, "exc");
   endtask

   task automatic r_type(input logic [5:0] fn, input logic [2:0] op);
      set_in(6'h00, fn, 1'b0, 1'b0);
      fetch();
      decode();
      cyc(4'd2, SRCA | AOW, 2'b00, 2'b00, op, "exec_r");
      cyc(4'd3, RW | RDST, 2'b00, 2'b00, 3'd0, "r_wb");
   endtask

   task automatic branch(input logic [5:0] op, input logic z, input logic taken);
      set_in(op, 6'h00, z, 1'b0);
      fetch();
      decode();
      cyc(4'd10, (taken ? PCW : 12'h000) | SRCA, 2'b00, 2'b01, 3'd2, "branch");
   endtask

   initial begin
      set_in(6'h00, 6'h00, 1'b0, 1'b0);
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      cyc(4'd0, 12'h000, 2'b01, 2'b00, 3'd1, "reset_hold");
      reset = 1'b1;

      // add, then add/addi with overflow while cause is still 0
      r_type(6'h20, 3'd1);

      set_in(6'h00, 6'h20, 1'b0, 1'b1);
      fetch();
      decode();
      cyc(4'd2, SRCA | AOW, 2'b00, 2'b00, 3'd1, "exec_add_ovf");
`ifdef CTRL_OVF_EXC_EN
      exc(2'd2);
`else
      cyc(4'd3, RW | RDST, 2'b00, 2'b00, 3'd0, "r_wb_ovf");
`endif

      set_in(6'h08, 6'h00, 1'b0, 1'b1);
      fetch();
      decode();
      cyc(4'd4, SRCA | AOW, 2'b10, 2'b00, 3'd1, "exec_i_ovf");
`ifdef CTRL_OVF_EXC_EN
      exc(2'd2);
`else
      cyc(4'd5, RW, 2'b00, 2'b00, 3'd0, "i_wb_ovf");
`endif

      set_in(6'h08, 6'h00, 1'b0, 1'b0);
      fetch();
      decode();
      cyc(4'd4, SRCA | AOW, 2'b10, 2'b00, 3'd1, "exec_i");
      cyc(4'd5, RW, 2'b00, 2'b00, 3'd0, "i_wb");

      r_type(6'h22, 3'd2);
      r_type(6'h24, 3'd3);
      r_type(6'h26, 3'd6);

      // lw: 3 fetch + decode + addr + 3 read + wb = 9 cycles
      set_in(6'h23, 6'h00, 1'b0, 1'b0);
      fetch();
      decode();
      cyc(4'd6, SRCA | AOW, 2'b10, 2'b00, 3'd1, "mem_addr_lw");
      for (int i = 0; i <= MW; i++)
         cyc(4'd7, IORD, 2'b00, 2'b00, 3'd0, "mem_read");
      cyc(4'd8, RW | M2R, 2'b00, 2'b00, 3'd0, "mem_wb");

      set_in(6'h2B, 6'h00, 1'b0, 1'b0);
      fetch();
      decode();
      cyc(4'd6, SRCA | AOW, 2'b10, 2'b00, 3'd1, "mem_addr_sw");
      cyc(4'd9, IORD | MWR, 2'b00, 2'b00, 3'd0, "mem_write");

      branch(6'h04, 1'b1, 1'b1);
      branch(6'h04, 1'b0, 1'b0);
      branch(6'h05, 1'b0, 1'b1);
      branch(6'h05, 1'b1, 1'b0);

      set_in(6'h02, 6'h00, 1'b0, 1'b0);
      fetch();
      decode();
      cyc(4'd11, PCW, 2'b00, 2'b10, 3'd0, "jump");

      // invalid funct and invalid opcode
      set_in(6'h00, 6'h3F, 1'b0, 1'b0);
      fetch();
      decode();
      cyc(4'd2, SRCA | AOW, 2'b00, 2'b00, 3'd0, "exec_bad_funct");
      exc(2'd1);

      set_in(6'h3F, 6'h00, 1'b0, 1'b0);
      fetch();
      decode();
      exc(2'd1);

      // cause holds across a normal instruction
      r_type(6'h20, 3'd1);

      // reset asserted in the middle of MEM_READ
      set_in(6'h23, 6'h00, 1'b0, 1'b0);
      fetch();
      decode();
      cyc(4'd6, SRCA | AOW, 2'b10, 2'b00, 3'd1, "mem_addr_rst");
      cyc(4'd7, IORD, 2'b00, 2'b00, 3'd0, "mem_read_rst");
      reset = 1'b0;
      exp_cause = 2'd0;
      cyc(4'd0, 12'h000, 2'b01, 2'b00, 3'd1, "reset_in_memread");
      cyc(4'd0, 12'h000, 2'b01, 2'b00, 3'd1, "reset_hold2");
      reset = 1'b1;
      r_type(6'h20, 3'd1);

      if (sb_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
